// File: rtl/uart_tx_feeder_pkg.sv
// Shared definitions for the UART transmit feeder: FSM encoding and default sizing.
package uart_tx_feeder_pkg;

    // Default FIFO sizing; DEPTH must equal 2**ADDR_W.
    localparam int DEPTH_DEF  = 16;
    localparam int ADDR_W_DEF = 4;

    // Issue sequencer states, 3-bit encoding visible on the debug state port.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_ACT  = 3'd2,
        ST_WAIT_DONE = 3'd3,
        ST_GAP       = 3'd4
    } feeder_state_t;

endpackage

// File: rtl/uart_byte_fifo.sv
// Synchronous byte FIFO with show-ahead read data, occupancy count and full/empty flags.
module uart_byte_fifo
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              wr_en,
    input  logic [7:0]        wr_byte,
    input  logic              rd_en,
    output logic [7:0]        rd_byte,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              empty
);

    localparam logic [ADDR_W:0] FULL_COUNT = DEPTH[ADDR_W:0];

    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              push_ok;
    logic              pop_ok;

    // Full is judged on the registered count, so a push while full is dropped even if a pop lands.
    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign push_ok = wr_en && !full;
    assign pop_ok  = rd_en && !empty;
    assign rd_byte = mem[rd_ptr];

    // Pointers wrap naturally at DEPTH; count saturates by construction (push blocked when full).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array carries no reset; only pointers define which entries are live.
    always_ff @(posedge CLK) begin
        if (push_ok) mem[wr_ptr] <= wr_byte;
    end

endmodule

// File: rtl/uart_tx_feeder.sv
// Byte FIFO plus issue sequencer feeding a UART_TX serializer in write order.
//
// UART_TX handshake: o_TX_DV is a 1-cycle request carrying o_TX_Byte. The serializer
// raises i_TX_Active while shifting and then holds i_TX_Done high for 2 cycles. A new
// request is only made when both Active and Done are low, so every DV is separated
// from the next by one Active rise and one Done fall.
module uart_tx_feeder
    import uart_tx_feeder_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_WR_EN,
    input  logic [7:0]        i_WR_Byte,
    output logic              o_Full,
    output logic              o_Empty,
    output logic [ADDR_W:0]   o_Count,
    output logic              o_Overflow,
    output logic              o_TX_DV,
    output logic [7:0]        o_TX_Byte,
    input  logic              i_TX_Active,
    input  logic              i_TX_Done,
    output logic [2:0]        o_State
);

    feeder_state_t state;
    logic [7:0]    head_byte;
    logic          pop;

    // Pop only from IDLE with data pending and the serializer fully quiet (covers reset mid-frame).
    assign pop     = (state == ST_IDLE) && !o_Empty && !i_TX_Active && !i_TX_Done;
    assign o_State = state;

    uart_byte_fifo #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .wr_en   (i_WR_EN),
        .wr_byte (i_WR_Byte),
        .rd_en   (pop),
        .rd_byte (head_byte),
        .count   (o_Count),
        .full    (o_Full),
        .empty   (o_Empty)
    );

    // Dropped-push flag: one cycle after a push attempt that found the FIFO full.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            o_Overflow <= 1'b0;
        end else begin
            o_Overflow <= i_WR_EN && o_Full;
        end
    end

    // Issue sequencer: launch one byte, then track Active and the 2-cycle Done back to IDLE.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state     <= ST_IDLE;
            o_TX_DV   <= 1'b0;
            o_TX_Byte <= 8'h00;
        end else begin
            o_TX_DV <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (pop) begin
                        o_TX_Byte <= head_byte;
                        o_TX_DV   <= 1'b1;
                        state     <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state <= ST_WAIT_ACT;
                end
                ST_WAIT_ACT: begin
                    if (i_TX_Active) state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (i_TX_Done) state <= ST_GAP;
                end
                ST_GAP: begin
                    if (!i_TX_Done) state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// Bench for uart_tx_feeder: behavioural UART_TX (4 clocks/bit) plus a line decoder.
module tb_uart_tx_feeder;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;
    localparam int CPB    = 4;

    // clock / reset
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    logic              i_WR_EN   = 1'b0;
    logic [7:0]        i_WR_Byte = 8'h00;
    logic              o_Full;
    logic              o_Empty;
    logic [ADDR_W:0]   o_Count;
    logic              o_Overflow;
    logic              o_TX_DV;
    logic [7:0]        o_TX_Byte;
    logic [2:0]        o_State;

    logic tx_active = 1'b0;
    logic tx_done   = 1'b0;
    logic tx_line   = 1'b1;
    logic hold_busy = 1'b0;
    logic dut_active;
    assign dut_active = tx_active | hold_busy;

    uart_tx_feeder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .CLK         (CLK),
        .RST         (RST),
        .i_WR_EN     (i_WR_EN),
        .i_WR_Byte   (i_WR_Byte),
        .o_Full      (o_Full),
        .o_Empty     (o_Empty),
        .o_Count     (o_Count),
        .o_Overflow  (o_Overflow),
        .o_TX_DV     (o_TX_DV),
        .o_TX_Byte   (o_TX_Byte),
        .i_TX_Active (dut_active),
        .i_TX_Done   (tx_done),
        .o_State     (o_State)
    );

    // behavioural UART_TX (no reset): start, 8 data LSB first, stop; Done high 2 cycles
    logic       m_busy     = 1'b0;
    logic [9:0] m_frame    = 10'h3FF;
    logic [3:0] m_bit      = 4'd0;
    logic [1:0] m_clk      = 2'd0;
    logic [1:0] m_done_cnt = 2'd0;

    always @(posedge CLK) begin
        if (m_done_cnt != 2'd0) begin
            m_done_cnt <= m_done_cnt - 2'd1;
            if (m_done_cnt == 2'd1) tx_done <= 1'b0;
        end
        if (!m_busy) begin
            if (o_TX_DV) begin
                m_busy    <= 1'b1;
                tx_active <= 1'b1;
                m_frame   <= {1'b1, o_TX_Byte, 1'b0};
                m_bit     <= 4'd0;
                m_clk     <= 2'd0;
                tx_line   <= 1'b0;
            end
        end else if (m_clk == 2'd3) begin
            m_clk <= 2'd0;
            if (m_bit == 4'd9) begin
                m_busy     <= 1'b0;
                tx_active  <= 1'b0;
                tx_done    <= 1'b1;
                m_done_cnt <= 2'd2;
                tx_line    <= 1'b1;
            end else begin
                m_bit   <= m_bit + 4'd1;
                tx_line <= m_frame[m_bit + 4'd1];
            end
        end else begin
            m_clk <= m_clk + 2'd1;
        end
    end

    // event monitors
    int   dv_count      = 0;
    int   ovf_count     = 0;
    int   dv_violations = 0;
    int   dv_wide       = 0;
    int   framing_err   = 0;
    logic prev_dv       = 1'b0;

    always @(negedge CLK) begin
        if (o_TX_DV) dv_count <= dv_count + 1;
        if (o_Overflow) ovf_count <= ovf_count + 1;
        if (o_TX_DV && (m_busy || tx_done)) dv_violations <= dv_violations + 1;
        if (o_TX_DV && prev_dv) dv_wide <= dv_wide + 1;
        prev_dv <= o_TX_DV;
    end

    // TX line decoder
    logic [7:0] rx_q  [$];
    logic [7:0] exp_q [$];

    initial begin
        logic [7:0] b;
        b = 8'h00;
        forever begin
            @(negedge CLK);
            if (tx_line == 1'b0) begin
                repeat (2) @(negedge CLK);
                if (tx_line != 1'b0) framing_err = framing_err + 1;
                for (int i = 0; i < 8; i++) begin
                    repeat (CPB) @(negedge CLK);
                    b[i] = tx_line;
                end
                repeat (CPB) @(negedge CLK);
                if (tx_line != 1'b1) framing_err = framing_err + 1;
                rx_q.push_back(b);
            end
        end
    end

    // scoreboard
    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    endtask

    // driver tasks
    task automatic push(input logic [7:0] b);
        @(negedge CLK);
        i_WR_EN   = 1'b1;
        i_WR_Byte = b;
        @(posedge CLK);
        #1 i_WR_EN = 1'b0;
    endtask

    task automatic wait_drain(input int budget, input string tag);
        int n;
        n = 0;
        while (!(o_Empty && o_State == 3'd0 && !tx_active && !tx_done && !o_TX_DV) && n < budget) begin
            @(negedge CLK);
            n++;
        end
        check({tag, "_drain_in_budget"}, (n < budget), 1);
        repeat (8) @(negedge CLK);
    endtask

    task automatic check_rx(input string tag);
        check({tag, "_rx_count"}, rx_q.size(), exp_q.size());
        while (exp_q.size() > 0 && rx_q.size() > 0)
            check({tag, "_rx_byte"}, rx_q.pop_front(), exp_q.pop_front());
        exp_q.delete();
        rx_q.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish expected finish");
        $fatal(1);
    end

    int dv0;
    int ovf0;
    int guard;
    int bad_dv;
    int bad_state;
    int bad_line;

    initial begin
        // ---- 1: reset values, single byte A5 ----
        repeat (3) @(negedge CLK);
        check("rst_empty", o_Empty, 1);
        check("rst_full", o_Full, 0);
        check("rst_count", o_Count, 0);
        check("rst_overflow", o_Overflow, 0);
        check("rst_dv", o_TX_DV, 0);
        check("rst_byte", o_TX_Byte, 8'h00);
        check("rst_state", o_State, 3'd0);
        RST = 1'b0;

        @(negedge CLK);
        i_WR_EN   = 1'b1;
        i_WR_Byte = 8'hA5;
        @(posedge CLK);
        #1 i_WR_EN = 1'b0;
        exp_q.push_back(8'hA5);
        @(negedge CLK);
        check("t1_dv_not_early", o_TX_DV, 0);
        check("t1_count_one", o_Count, 1);
        @(negedge CLK);
        check("t1_dv_high", o_TX_DV, 1);
        check("t1_dv_byte", o_TX_Byte, 8'hA5);
        @(negedge CLK);
        check("t1_dv_one_cycle", o_TX_DV, 0);
        wait_drain(500, "t1");
        check_rx("t1");
        check("t1_empty_after", o_Empty, 1);
        check("t1_line_idle", tx_line, 1);

        // ---- 2: 16 consecutive pushes, full, drained in order ----
        dv0  = dv_count;
        ovf0 = ovf_count;
        @(negedge CLK);
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(8'(i));
            exp_q.push_back(8'(i));
        end
        @(negedge CLK);
        check("t2_full", o_Full, 1);
        check("t2_count16", o_Count, 16);
        hold_busy = 1'b0;
        wait_drain(2000, "t2");
        check_rx("t2");
        check("t2_dv_pulses", dv_count - dv0, 16);
        check("t2_no_overflow", ovf_count - ovf0, 0);

        // ---- 3: overflow while full ----
        ovf0 = ovf_count;
        @(negedge CLK);
        hold_busy = 1'b1;
        for (int i = 0; i < 16; i++) begin
            push(8'(8'h20 + i));
            exp_q.push_back(8'(8'h20 + i));
        end
        push(8'hFF);
        check("t3_overflow_pulse", o_Overflow, 1);
        check("t3_count_stays16", o_Count, 16);
        @(posedge CLK);
        #1;
        check("t3_overflow_one_cycle", o_Overflow, 0);
        check("t3_count_still16", o_Count, 16);
        @(negedge CLK);
        hold_busy = 1'b0;
        wait_drain(2000, "t3");
        check_rx("t3");
        check("t3_overflow_count", ovf_count - ovf0, 1);

        // ---- 4: push+pop at count 3, 40 bytes across pointer wrap ----
        ovf0 = ovf_count;
        @(negedge CLK);
        hold_busy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(8'(8'h40 + i));
            exp_q.push_back(8'(8'h40 + i));
        end
        @(negedge CLK);
        check("t4_count3", o_Count, 3);
        i_WR_EN   = 1'b1;
        i_WR_Byte = 8'h43;
        hold_busy = 1'b0;
        exp_q.push_back(8'h43);
        @(posedge CLK);
        #1 i_WR_EN = 1'b0;
        check("t4_pushpop_count", o_Count, 3);
        check("t4_pushpop_dv", o_TX_DV, 1);
        check("t4_pushpop_byte", o_TX_Byte, 8'h40);
        guard = 0;
        for (int i = 4; i < 40; i++) begin
            while (o_Count >= 12 && guard < 3000) begin
                @(negedge CLK);
                guard++;
            end
            push(8'(8'h40 + i));
            exp_q.push_back(8'(8'h40 + i));
        end
        check("t4_push_in_budget", (guard < 3000), 1);
        wait_drain(2000, "t4");
        check_rx("t4");
        check("t4_no_overflow", ovf_count - ovf0, 0);

        // ---- 5: async reset mid data bit of byte 2 of 5 ----
        dv0 = dv_count;
        for (int i = 0; i < 5; i++) push(8'(8'h50 + i));
        exp_q.push_back(8'h50);
        exp_q.push_back(8'h51);
        guard = 0;
        while (dv_count != dv0 + 2 && guard < 500) begin
            @(negedge CLK);
            guard++;
        end
        check("t5_second_dv_seen", (guard < 500), 1);
        repeat (10) @(negedge CLK);
        #2 RST = 1'b1;
        #1;
        check("t5_rst_count", o_Count, 0);
        check("t5_rst_empty", o_Empty, 1);
        check("t5_rst_state", o_State, 3'd0);
        check("t5_uart_still_active", tx_active, 1);
        @(negedge CLK);
        RST = 1'b0;
        push(8'h3C);
        exp_q.push_back(8'h3C);
        @(negedge CLK);
        check("t5_dv_held_off", o_TX_DV, 0);
        check("t5_pending_one", o_Count, 1);
        wait_drain(1000, "t5");
        check_rx("t5");
        check("t5_dv_after_reset", dv_count - dv0, 3);

        // ---- 6: idle for 100 cycles ----
        bad_dv    = 0;
        bad_state = 0;
        bad_line  = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge CLK);
            if (o_TX_DV !== 1'b0) bad_dv++;
            if (o_State !== 3'd0) bad_state++;
            if (tx_line !== 1'b1) bad_line++;
        end
        check("t6_dv_quiet", bad_dv, 0);
        check("t6_state_idle", bad_state, 0);
        check("t6_line_high", bad_line, 0);

        // global protocol monitors
        check("dv_while_busy", dv_violations, 0);
        check("dv_width", dv_wide, 0);
        check("line_framing", framing_err, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
